// File: rtl/game_pkg.sv
// Shared game-flow types: state encoding, BCD digit type and
// the step-period helper used by the controller.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Halve the base period per level, never below one cycle.
    function automatic int unsigned step_period(
        input int unsigned base_div,
        input int unsigned lvl
    );
        int unsigned p;
        p = base_div >> lvl;
        return (p == 0) ? 1 : p;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear that
// saturates at all nines instead of wrapping.
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_inc_bcd;
    logic                w_full;
    logic                w_carry;

    always_comb begin
        w_inc_bcd = r_bcd;
        w_full    = 1'b1;
        w_carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != BCD_NINE) begin
                w_full = 1'b0;
            end
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == BCD_NINE) begin
                    w_inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    w_inc_bcd[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd <= '0;
        end else if (clr) begin
            r_bcd <= '0;
        end else if (inc && !w_full) begin
            r_bcd <= w_inc_bcd;
        end
    end

    assign bcd = r_bcd;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: title/play/pause/over FSM, score and
// high score, difficulty level and the game-step tick.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int LEVEL_PTS = 10,
    parameter int LEVELS    = 4,
    parameter int BASE_DIV  = 64,
    parameter int DIV_W     = 8,
    localparam int LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  collision,
    input  logic                  incr,
    output logic [1:0]            game_state,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   hi_bcd,
    output logic [LVL_W-1:0]      level,
    output logic                  step
);

    localparam int PTS_W = $clog2(LEVEL_PTS + 1);
    localparam logic [DIV_W-1:0] FIRST_LOAD =
        DIV_W'(step_period(BASE_DIV, 0) - 1);

    game_state_t         r_state;
    game_state_t         w_next;
    logic                r_start_q;
    logic                r_pause_q;
    logic                w_start_edge;
    logic                w_pause_edge;
    logic                w_accept;
    logic                w_clr;
    logic                w_to_over;
    logic                w_run;
    logic [LVL_W-1:0]    r_level;
    logic [PTS_W-1:0]    r_pts;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    w_reload;
    logic                r_step;
    logic [4*DIGITS-1:0] r_hi;
    logic [4*DIGITS-1:0] w_score;

    assign w_start_edge = start & ~r_start_q;
    assign w_pause_edge = pause & ~r_pause_q;
    assign w_reload =
        DIV_W'(step_period(BASE_DIV, 32'(r_level)) - 1);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_clr     = 1'b0;
        w_to_over = 1'b0;
        unique case (r_state)
            TITLE: begin
                if (w_start_edge) begin
                    w_next = PLAY;
                    w_clr  = 1'b1;
                end
            end
            PLAY: begin
                if (collision) begin
                    w_next    = OVER;
                    w_to_over = 1'b1;
                end else if (w_pause_edge) begin
                    w_next = PAUSE;
                end else begin
                    w_accept = incr;
                end
            end
            PAUSE: begin
                if (w_pause_edge) w_next = PLAY;
            end
            OVER: begin
                if (w_start_edge) w_next = TITLE;
            end
            default: w_next = TITLE;
        endcase
    end

    // Only cycles that stay in PLAY advance the tick, so a pause
    // resumes with exactly the remaining count.
    assign w_run = (r_state == PLAY) && (w_next == PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TITLE;
            r_start_q <= 1'b1;
            r_pause_q <= 1'b1;
            r_hi      <= '0;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
            r_pause_q <= pause;
            if (w_to_over && (w_score > r_hi)) begin
                r_hi <= w_score;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_level <= '0;
            r_pts   <= '0;
        end else if (w_accept) begin
            if (r_pts == PTS_W'(LEVEL_PTS - 1)) begin
                r_pts <= '0;
                if (r_level != LVL_W'(LEVELS - 1)) begin
                    r_level <= r_level + LVL_W'(1);
                end
            end else begin
                r_pts <= r_pts + PTS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_clr) begin
                r_cnt <= FIRST_LOAD;
            end else if (w_run) begin
                if (r_cnt == '0) begin
                    r_step <= 1'b1;
                    r_cnt  <= w_reload;
                end else begin
                    r_cnt <= r_cnt - DIV_W'(1);
                end
            end
        end
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_accept),
        .bcd   (w_score)
    );

    assign game_state = r_state;
    assign score_bcd  = w_score;
    assign hi_bcd     = r_hi;
    assign level      = r_level;
    assign step       = r_step;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: flow, score, level, step pacing,
// high-score retention and mid-game reset.
module tb_game_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pause;
    logic        collision;
    logic        incr;
    logic [1:0]  game_state;
    logic [11:0] score_bcd;
    logic [11:0] hi_bcd;
    logic [1:0]  level;
    logic        step;

    int n_chk;
    int n_bad;

    game_ctrl #(
        .DIGITS    (3),
        .LEVEL_PTS (10),
        .LEVELS    (4),
        .BASE_DIV  (8),
        .DIV_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .collision  (collision),
        .incr       (incr),
        .game_state (game_state),
        .score_bcd  (score_bcd),
        .hi_bcd     (hi_bcd),
        .level      (level),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press_pause();
        pause = 1'b1;
        tick();
        pause = 1'b0;
    endtask

    task automatic incr_n(input int n);
        incr = 1'b1;
        repeat (n) tick();
        incr = 1'b0;
    endtask

    task automatic gap(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 20);
        chk(tag, 32'(n), 32'(exp));
    endtask

    task automatic sync_step();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 20);
        chk("sync", 32'(step), 32'd1);
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b1;
        pause     = 1'b0;
        collision = 1'b0;
        incr      = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_score", 32'(score_bcd), 32'h000);
        chk("rst_hi", 32'(hi_bcd), 32'h000);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_step", 32'(step), 32'd0);

        reset = 1'b0;
        tick();
        tick();
        chk("title_held", 32'(game_state), 32'd0);
        start = 1'b0;
        tick();
        press_start();
        chk("g1_play", 32'(game_state), 32'd1);
        chk("g1_score", 32'(score_bcd), 32'h000);
        chk("g1_level", 32'(level), 32'd0);

        gap("gap_l0a", 8);
        gap("gap_l0b", 8);
        repeat (3) tick();
        press_pause();
        chk("paused", 32'(game_state), 32'd2);
        incr      = 1'b1;
        collision = 1'b1;
        repeat (4) tick();
        chk("pause_coll", 32'(game_state), 32'd2);
        chk("pause_incr", 32'(score_bcd), 32'h000);
        chk("pause_step", 32'(step), 32'd0);
        incr      = 1'b0;
        collision = 1'b0;
        press_start();
        chk("pause_start", 32'(game_state), 32'd2);
        press_pause();
        chk("resumed", 32'(game_state), 32'd1);
        gap("gap_resume", 5);

        incr_n(7);
        chk("g1_007", 32'(score_bcd), 32'h007);
        collision = 1'b1;
        incr      = 1'b1;
        tick();
        collision = 1'b0;
        incr      = 1'b0;
        chk("g1_over", 32'(game_state), 32'd3);
        chk("g1_drop", 32'(score_bcd), 32'h007);
        chk("g1_hi", 32'(hi_bcd), 32'h007);
        chk("over_step", 32'(step), 32'd0);
        press_start();
        chk("to_title", 32'(game_state), 32'd0);

        tick();
        press_start();
        chk("g2_play", 32'(game_state), 32'd1);
        chk("g2_clr", 32'(score_bcd), 32'h000);
        incr_n(5);
        chk("g2_005", 32'(score_bcd), 32'h005);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("g2_over", 32'(game_state), 32'd3);
        chk("g2_hi", 32'(hi_bcd), 32'h007);
        press_start();
        tick();
        press_start();
        chk("g3_play", 32'(game_state), 32'd1);

        incr_n(10);
        chk("s010", 32'(score_bcd), 32'h010);
        chk("lvl1", 32'(level), 32'd1);
        sync_step();
        gap("gap_l1", 4);
        incr_n(15);
        chk("s025", 32'(score_bcd), 32'h025);
        chk("lvl2", 32'(level), 32'd2);
        sync_step();
        gap("gap_l2", 2);
        incr_n(5);
        chk("lvl3", 32'(level), 32'd3);
        sync_step();
        gap("gap_l3a", 1);
        gap("gap_l3b", 1);

        incr_n(969);
        chk("s999", 32'(score_bcd), 32'h999);
        incr_n(1);
        chk("sat999", 32'(score_bcd), 32'h999);
        chk("lvl_sat", 32'(level), 32'd3);
        chk("step_l3", 32'(step), 32'd1);

        reset = 1'b1;
        incr  = 1'b1;
        tick();
        reset = 1'b0;
        incr  = 1'b0;
        chk("mid_state", 32'(game_state), 32'd0);
        chk("mid_score", 32'(score_bcd), 32'h000);
        chk("mid_hi", 32'(hi_bcd), 32'h000);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_step", 32'(step), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
